// File: rtl/bp_cce_hybrid_lce_cmd_arb.sv
// ----------------------------------------------------------------------------
// bp_cce_hybrid_lce_cmd_arb
//
// Merges the BedRock Burst LCE command streams of several sources (source 0
// is the hybrid control module, the others are CCE pipelines) onto the single
// LCE command network port.
//
// Arbitration is round-robin over header valids. A granted message carrying
// data locks the arbiter to its source until the last data beat is accepted,
// so the header and data of one message are never interleaved with another.
// Header and data each pass through a 2-entry buffer; the source-side readys
// depend only on buffer occupancy, never on downstream ready.
//
// Ports
//   clk_i                      clock
//   reset_n_i                  asynchronous active-low reset
//   src_header_i               per-source header, num_src_p x header width
//   src_header_v_i             per-source header valid
//   src_header_ready_and_o     per-source header accept
//   src_has_data_i             per-source "message carries data" flag
//   src_data_i                 per-source data beat
//   src_data_v_i               per-source data valid
//   src_data_ready_and_o       per-source data accept
//   src_last_i                 per-source final-beat flag
//   lce_cmd_header_o/_v_o      merged header and valid (header buffer head)
//   lce_cmd_header_ready_and_i downstream header ready
//   lce_cmd_has_data_o         has_data flag travelling with the header
//   lce_cmd_data_o/_v_o        merged data beat and valid (data buffer head)
//   lce_cmd_data_ready_and_i   downstream data ready
//   lce_cmd_last_o             last flag travelling with the data beat
// ----------------------------------------------------------------------------

// Two-entry FIFO used for both the header and the data path.
//   data_i/v_i/ready_o : enqueue side (ready_o = not full)
//   data_o/v_o/yumi_i  : dequeue side (v_o = not empty, yumi_i pops the head)
module bp_cce_hybrid_lce_cmd_arb_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               wptr_r;
    logic               rptr_r;
    logic [1:0]         count_r;
    logic               push;
    logic               pop;

    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[rptr_r];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    // NOTE: storage is not reset; validity is carried entirely by count_r, so
    // clearing the entries would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (push) wptr_r <= ~wptr_r;
            if (pop)  rptr_r <= ~rptr_r;
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

module bp_cce_hybrid_lce_cmd_arb #(
    parameter int num_src_p                   = 3,
    parameter int lce_data_width_p            = 64,
    // BedRock LCE command header width; derived from the processor
    // configuration in the full system, exposed here so it can be set.
    parameter int lce_cmd_msg_header_width_lp = 64
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,

    input  logic [num_src_p*lce_cmd_msg_header_width_lp-1:0] src_header_i,
    input  logic [num_src_p-1:0]                          src_header_v_i,
    output logic [num_src_p-1:0]                          src_header_ready_and_o,
    input  logic [num_src_p-1:0]                          src_has_data_i,
    input  logic [num_src_p*lce_data_width_p-1:0]         src_data_i,
    input  logic [num_src_p-1:0]                          src_data_v_i,
    output logic [num_src_p-1:0]                          src_data_ready_and_o,
    input  logic [num_src_p-1:0]                          src_last_i,

    output logic [lce_cmd_msg_header_width_lp-1:0]        lce_cmd_header_o,
    output logic                                          lce_cmd_header_v_o,
    input  logic                                          lce_cmd_header_ready_and_i,
    output logic                                          lce_cmd_has_data_o,
    output logic [lce_data_width_p-1:0]                   lce_cmd_data_o,
    output logic                                          lce_cmd_data_v_o,
    input  logic                                          lce_cmd_data_ready_and_i,
    output logic                                          lce_cmd_last_o
);

    localparam int lg_num_src_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
    localparam int hdr_w_lp      = lce_cmd_msg_header_width_lp;
    localparam int data_w_lp     = lce_data_width_p;

    typedef enum logic {
        e_ready = 1'b0,
        e_data  = 1'b1
    } state_e;

    state_e                   state_r, state_n;
    logic [lg_num_src_lp-1:0] rr_ptr_r, rr_ptr_n;
    logic [lg_num_src_lp-1:0] lock_id_r, lock_id_n;

    logic                     grant_v;
    logic [lg_num_src_lp-1:0] grant_id;
    logic [lg_num_src_lp-1:0] grant_id_inc;

    logic                     hdr_fifo_ready;
    logic                     hdr_push;
    logic                     data_fifo_ready;
    logic                     data_push;

    logic [hdr_w_lp:0]        hdr_fifo_in;
    logic [hdr_w_lp:0]        hdr_fifo_out;
    logic [data_w_lp:0]       data_fifo_in;
    logic [data_w_lp:0]       data_fifo_out;

    // ------------------------------------------------------------------------
    // Round-robin pick: first valid header scanning upward from rr_ptr_r.
    // ------------------------------------------------------------------------
    always_comb begin
        int idx;
        grant_v  = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int k = 0; k < num_src_p; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= num_src_p) idx = idx - num_src_p;
            if (!grant_v && src_header_v_i[idx]) begin
                grant_v  = 1'b1;
                grant_id = lg_num_src_lp'(idx);
            end
        end
    end

    // Pointer advance past the winner, wrapping at the last source; with a
    // single source this is always 0.
    assign grant_id_inc = (grant_id == lg_num_src_lp'(num_src_p - 1))
                        ? '0 : grant_id + 1'b1;

    // Buffer inputs are steered from the granted / locked source.
    assign hdr_fifo_in  = {src_header_i[grant_id*hdr_w_lp +: hdr_w_lp],
                           src_has_data_i[grant_id]};
    assign data_fifo_in = {src_data_i[lock_id_r*data_w_lp +: data_w_lp],
                           src_last_i[lock_id_r]};

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= e_ready;
            rr_ptr_r  <= '0;
            lock_id_r <= '0;
        end else begin
            state_r   <= state_n;
            rr_ptr_r  <= rr_ptr_n;
            lock_id_r <= lock_id_n;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and source handshakes
    // ------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_n                = state_r;
        rr_ptr_n               = rr_ptr_r;
        lock_id_n              = lock_id_r;
        hdr_push               = 1'b0;
        data_push              = 1'b0;
        src_header_ready_and_o = '0;
        src_data_ready_and_o   = '0;

        case (state_r)
            e_ready: begin
                // Data is never accepted here, even when it arrives alongside
                // its own header; the beat waits for the lock.
                if (grant_v) begin
                    src_header_ready_and_o[grant_id] = hdr_fifo_ready & reset_n_i;
                    hdr_push = hdr_fifo_ready;
                end
                if (hdr_push) begin
                    rr_ptr_n = grant_id_inc;
                    if (src_has_data_i[grant_id]) begin
                        lock_id_n = grant_id;
                        state_n   = e_data;
                    end
                end
            end
            e_data: begin
                // Only the locked source can move data; stray beats from other
                // sources are never acknowledged.
                src_data_ready_and_o[lock_id_r] = data_fifo_ready & reset_n_i;
                data_push = data_fifo_ready & src_data_v_i[lock_id_r];
                if (data_push && src_last_i[lock_id_r]) begin
                    state_n = e_ready;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output buffers
    // ------------------------------------------------------------------------
    bp_cce_hybrid_lce_cmd_arb_fifo #(.width_p(hdr_w_lp + 1)) hdr_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (hdr_fifo_in),
        .v_i       (hdr_push),
        .ready_o   (hdr_fifo_ready),
        .data_o    (hdr_fifo_out),
        .v_o       (lce_cmd_header_v_o),
        .yumi_i    (lce_cmd_header_ready_and_i)
    );

    bp_cce_hybrid_lce_cmd_arb_fifo #(.width_p(data_w_lp + 1)) data_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (data_fifo_in),
        .v_i       (data_push),
        .ready_o   (data_fifo_ready),
        .data_o    (data_fifo_out),
        .v_o       (lce_cmd_data_v_o),
        .yumi_i    (lce_cmd_data_ready_and_i)
    );

    assign {lce_cmd_header_o, lce_cmd_has_data_o} = hdr_fifo_out;
    assign {lce_cmd_data_o, lce_cmd_last_o}       = data_fifo_out;

endmodule
